rtc_bus_interface: RTL and testbench
====================================

RTC_BUS_INTERFACE -- requirements
Module: rtc_bus_interface

Interface
REQ-001 The block SHALL have parameter T_PHASE, default 10, giving clock cycles per bus phase (100 ns at 100 MHz).
REQ-002 The block SHALL have parameter T_GAP, default 4, giving idle cycles after each transaction before a new one may start.
REQ-003 Ports SHALL be:
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset
- port_id  in  8  PicoBlaze port address
- out_port  in  8  PicoBlaze write data
- write_strobe  in  1  PicoBlaze write qualifier
- read_strobe  in  1  PicoBlaze read qualifier
- in_port  out  8  read-data mux to PicoBlaze
- rtc_cs_n  out  1  RTC chip select, active low
- rtc_rd_n  out  1  RTC read strobe, active low
- rtc_wr_n  out  1  RTC write strobe, active low
- rtc_ad  out  1  A/D select: 0 = address phase, 1 = data phase
- ad_out  out  8  multiplexed bus drive value
- ad_oe  out  1  tristate enable for ad_out; the pad tristate is outside this block
- ad_in  in  8  multiplexed bus sampled value
- busy  out  1  transaction in progress

Function
REQ-004 The port map SHALL be:
- 0x10 ADDR (write)
- 0x11 WDATA (write)
- 0x12 CMD (write; bit0 = 1 for write, 0 for read; the write starts a transaction)
- 0x13 STATUS (read; bit0 = busy, bit1 = done)
- 0x14 RDATA (read)
REQ-005 ADDR and WDATA staging registers SHALL load out_port on write_strobe at their port at any time, including while busy.
REQ-006 On a CMD write in IDLE, the FSM SHALL capture ADDR, WDATA and bit0 into transaction registers. busy SHALL assert the next cycle.
REQ-007 A CMD write while busy=1 or during GAP SHALL be ignored, with no queuing.
REQ-008 FSM states SHALL be IDLE, A_SETUP, A_STROBE, A_HOLD, D_SETUP, D_STROBE, D_HOLD, GAP. Each A_/D_ state lasts T_PHASE cycles; GAP lasts T_GAP cycles; GAP then returns to IDLE.
REQ-009 Address phase (A_*) outputs SHALL be:
- rtc_ad = 0, ad_oe = 1, ad_out = captured address
- rtc_cs_n = 0 in all A_* states
- rtc_wr_n = 0 only in A_STROBE
REQ-010 Data phase (D_*) outputs SHALL be:
- rtc_ad = 1, rtc_cs_n = 0
- Write: ad_oe = 1, ad_out = captured data, rtc_wr_n = 0 only in D_STROBE
- Read: ad_oe = 0, rtc_rd_n = 0 only in D_STROBE
REQ-011 On a read, RDATA SHALL load ad_in on the last cycle of D_STROBE. On a write, RDATA SHALL be unchanged.
REQ-012 In IDLE and GAP, bus outputs SHALL be: rtc_cs_n = rtc_rd_n = rtc_wr_n = 1, rtc_ad = 1, ad_oe = 0, ad_out = 0x00.
REQ-013 rtc_rd_n and rtc_wr_n SHALL never be low in the same cycle.
REQ-014 All bus outputs SHALL be registered (glitch-free).
REQ-015 busy SHALL be 1 from the cycle after the accepted CMD through the last GAP cycle. Total busy length = 6*T_PHASE + T_GAP cycles.
REQ-016 done SHALL be sticky: it sets on the GAP→IDLE transition.
REQ-017 done SHALL clear on read_strobe with port_id = 0x13, or on an accepted CMD. If set and clear occur in the same cycle, set wins.
REQ-018 in_port SHALL be a combinational mux of port_id: 0x13 → {6'b0, done, busy}, 0x14 → RDATA, any other port → 0x00.
REQ-019 Phase counters SHALL be wide enough for max(T_PHASE, T_GAP) and SHALL reload to 0 on each state entry.

Reset
REQ-020 While reset = 0 at a rising edge, the block SHALL enter IDLE and clear:
- ADDR, WDATA, RDATA, done and busy to 0
- bus outputs to the REQ-012 values
REQ-021 Reset asserted mid-transaction SHALL abort it within one cycle. No strobe pulse shall be truncated to less than one cycle. done SHALL not set.

Structure
REQ-022 A shared package SHALL hold:
- port address constants 0x10–0x14
- the FSM state enumeration
- CMD/STATUS bit positions
- the T_PHASE/T_GAP default values
REQ-023 A single sub-module, rtc_phase_timer, SHALL implement the reloadable down-counter with terminal-count output. The FSM and register file SHALL remain in rtc_bus_interface.

Verification
REQ-024 Write cycle: ADDR=0x21, WDATA=0x45, CMD=0x01 → ad_out 0x21 with wr_n low for 10 cycles, then ad_out 0x45 with wr_n low for 10 cycles; busy high for 64 cycles; STATUS reads 0x02, then 0x00 on re-read.
REQ-025 Read cycle: ADDR=0x22, CMD=0x00, ad_in=0x37 during D_STROBE → ad_oe=0 and rd_n low for 10 cycles in the data phase; RDATA reads 0x37; wr_n never low in the data phase.
REQ-026 A CMD write at busy cycle 5, and at the first GAP cycle → both ignored; exactly one transaction on the bus; ADDR written mid-transaction does not alter ad_out.
REQ-027 reset=0 during D_STROBE of a write → next cycle cs_n/wr_n=1, ad_oe=0, busy=0, done=0; a following transaction completes normally.
REQ-028 STATUS read in the same cycle as done sets → done reads 1 afterwards; unmapped port_id 0x55 → in_port 0x00.

Source files
------------

// File: rtl/rtc_bus_interface_pkg.sv
// Shared definitions for the PicoBlaze-to-RTC multiplexed bus bridge:
// port map, register bit positions, timing defaults, FSM states and bus drive encoding.
package rtc_bus_interface_pkg;

    localparam logic [7:0] PORT_ADDR   = 8'h10;
    localparam logic [7:0] PORT_WDATA  = 8'h11;
    localparam logic [7:0] PORT_CMD    = 8'h12;
    localparam logic [7:0] PORT_STATUS = 8'h13;
    localparam logic [7:0] PORT_RDATA  = 8'h14;

    localparam int CMD_WRITE_BIT   = 0;
    localparam int STATUS_BUSY_BIT = 0;
    localparam int STATUS_DONE_BIT = 1;

    localparam int T_PHASE_DEFAULT = 10;
    localparam int T_GAP_DEFAULT   = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_A_SETUP,
        ST_A_STROBE,
        ST_A_HOLD,
        ST_D_SETUP,
        ST_D_STROBE,
        ST_D_HOLD,
        ST_GAP
    } rtc_state_e;

    typedef struct packed {
        logic       cs_n;
        logic       rd_n;
        logic       wr_n;
        logic       ad;
        logic       oe;
        logic [7:0] data;
    } bus_t;

    localparam bus_t BUS_IDLE = '{cs_n: 1'b1, rd_n: 1'b1, wr_n: 1'b1, ad: 1'b1, oe: 1'b0, data: 8'h00};

    function automatic rtc_state_e next_state(rtc_state_e s);
        rtc_state_e n;
        case (s)
            ST_A_SETUP:  n = ST_A_STROBE;
            ST_A_STROBE: n = ST_A_HOLD;
            ST_A_HOLD:   n = ST_D_SETUP;
            ST_D_SETUP:  n = ST_D_STROBE;
            ST_D_STROBE: n = ST_D_HOLD;
            ST_D_HOLD:   n = ST_GAP;
            default:     n = ST_IDLE;
        endcase
        return n;
    endfunction

    // Bus pin values for a state; read and write strobes are mutually exclusive by construction.
    function automatic bus_t bus_drive(rtc_state_e s, logic wr, logic [7:0] addr, logic [7:0] data);
        bus_t b;
        b = BUS_IDLE;
        case (s)
            ST_A_SETUP, ST_A_STROBE, ST_A_HOLD: begin
                b.cs_n = 1'b0;
                b.ad   = 1'b0;
                b.oe   = 1'b1;
                b.data = addr;
                b.wr_n = (s != ST_A_STROBE);
            end
            ST_D_SETUP, ST_D_STROBE, ST_D_HOLD: begin
                b.cs_n = 1'b0;
                b.ad   = 1'b1;
                if (wr) begin
                    b.oe   = 1'b1;
                    b.data = data;
                    b.wr_n = (s != ST_D_STROBE);
                end else begin
                    b.rd_n = (s != ST_D_STROBE);
                end
            end
            default: b = BUS_IDLE;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/rtc_bus_interface_phase_timer.sv
// Reloadable down-counter: load sets the remaining cycles minus one, tc flags the last cycle.
module rtc_phase_timer #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign tc = (cnt_q == '0);

endmodule

// File: rtl/rtc_bus_interface.sv
// PicoBlaze I/O-port bridge to a multiplexed-address/data RTC bus.
// Strobes are single-cycle qualifiers: a write/read takes effect on the rising edge where its strobe is high.
module rtc_bus_interface
    import rtc_bus_interface_pkg::*;
#(
    parameter int T_PHASE = T_PHASE_DEFAULT,
    parameter int T_GAP   = T_GAP_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] port_id,
    input  logic [7:0] out_port,
    input  logic       write_strobe,
    input  logic       read_strobe,
    output logic [7:0] in_port,
    output logic       rtc_cs_n,
    output logic       rtc_rd_n,
    output logic       rtc_wr_n,
    output logic       rtc_ad,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    input  logic [7:0] ad_in,
    output logic       busy
);

    localparam int CNT_MAX = (T_PHASE > T_GAP) ? T_PHASE : T_GAP;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] PHASE_LOAD = CW'(T_PHASE - 1);
    localparam logic [CW-1:0] GAP_LOAD   = CW'(T_GAP - 1);

    rtc_state_e  state_q, state_d;
    logic [7:0]  addr_q, wdata_q, rdata_q;
    logic [7:0]  tx_addr_q, tx_data_q;
    logic        tx_wr_q;
    logic        done_q, busy_q;
    bus_t        bus_q;

    logic        cmd_wr, status_rd, start, advance, tc;
    logic        timer_load;
    logic [CW-1:0] timer_val;
    logic        wr_sel;
    logic [7:0]  addr_sel, data_sel;

    assign cmd_wr    = write_strobe && (port_id == PORT_CMD);
    assign status_rd = read_strobe && (port_id == PORT_STATUS);
    assign start     = cmd_wr && (state_q == ST_IDLE);
    assign advance   = (state_q != ST_IDLE) && tc;

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = ST_A_SETUP;
        end else if (advance) begin
            state_d = next_state(state_q);
        end
    end

    assign timer_load = start || advance;
    assign timer_val  = (state_d == ST_GAP) ? GAP_LOAD : PHASE_LOAD;

    // On the accepting edge the transaction registers are not yet loaded, so drive from the staging values.
    assign wr_sel   = start ? out_port[CMD_WRITE_BIT] : tx_wr_q;
    assign addr_sel = start ? addr_q  : tx_addr_q;
    assign data_sel = start ? wdata_q : tx_data_q;

    rtc_phase_timer #(.W(CW)) u_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (timer_load),
        .load_val (timer_val),
        .tc       (tc)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            addr_q    <= 8'h00;
            wdata_q   <= 8'h00;
            rdata_q   <= 8'h00;
            tx_addr_q <= 8'h00;
            tx_data_q <= 8'h00;
            tx_wr_q   <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            bus_q     <= BUS_IDLE;
        end else begin
            if (write_strobe && (port_id == PORT_ADDR)) begin
                addr_q <= out_port;
            end
            if (write_strobe && (port_id == PORT_WDATA)) begin
                wdata_q <= out_port;
            end
            if (start) begin
                tx_addr_q <= addr_q;
                tx_data_q <= wdata_q;
                tx_wr_q   <= out_port[CMD_WRITE_BIT];
            end
            if ((state_q == ST_D_STROBE) && tc && !tx_wr_q) begin
                rdata_q <= ad_in;
            end
            // Completion outranks a coincident clear so a STATUS poll cannot lose it.
            if ((state_q == ST_GAP) && tc) begin
                done_q <= 1'b1;
            end else if (status_rd || start) begin
                done_q <= 1'b0;
            end
            state_q <= state_d;
            busy_q  <= (state_d != ST_IDLE);
            bus_q   <= bus_drive(state_d, wr_sel, addr_sel, data_sel);
        end
    end

    always_comb begin
        in_port = 8'h00;
        case (port_id)
            PORT_STATUS: begin
                in_port[STATUS_BUSY_BIT] = busy_q;
                in_port[STATUS_DONE_BIT] = done_q;
            end
            PORT_RDATA:  in_port = rdata_q;
            default:     in_port = 8'h00;
        endcase
    end

    assign rtc_cs_n = bus_q.cs_n;
    assign rtc_rd_n = bus_q.rd_n;
    assign rtc_wr_n = bus_q.wr_n;
    assign rtc_ad   = bus_q.ad;
    assign ad_oe    = bus_q.oe;
    assign ad_out   = bus_q.data;
    assign busy     = busy_q;

endmodule

// File: tb/tb_rtc_bus_interface.sv
// Bench for rtc_bus_interface: cycle-accurate waveform model derived from transaction timing arithmetic,
// a table of transactions, directed corner sequences and a randomized port-traffic phase.
module tb_rtc_bus_interface;

    localparam int TP    = 10;
    localparam int TG    = 4;
    localparam int TOTAL = 6 * TP + TG;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] port_id = 8'h00;
    logic [7:0] out_port = 8'h00;
    logic       write_strobe = 1'b0;
    logic       read_strobe = 1'b0;
    logic [7:0] ad_in = 8'h00;
    logic [7:0] in_port, ad_out;
    logic       rtc_cs_n, rtc_rd_n, rtc_wr_n, rtc_ad, ad_oe, busy;

    int checks = 0;
    int errors = 0;

    rtc_bus_interface #(.T_PHASE(TP), .T_GAP(TG)) dut (
        .clock        (clock),
        .reset        (reset),
        .port_id      (port_id),
        .out_port     (out_port),
        .write_strobe (write_strobe),
        .read_strobe  (read_strobe),
        .in_port      (in_port),
        .rtc_cs_n     (rtc_cs_n),
        .rtc_rd_n     (rtc_rd_n),
        .rtc_wr_n     (rtc_wr_n),
        .rtc_ad       (rtc_ad),
        .ad_out       (ad_out),
        .ad_oe        (ad_oe),
        .ad_in        (ad_in),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit         m_active = 0;
    int         m_c = 0;
    bit         m_wr = 0;
    logic [7:0] m_taddr = 0, m_tdata = 0, m_addr_stg = 0, m_wdata_stg = 0, m_rdata = 0;
    bit         m_done = 0;

    // Expected {cs_n, rd_n, wr_n, ad, oe, data} for cycle c of a transaction: three phases of
    // setup/strobe/hold, address then data, then the gap which looks idle on the pins.
    function automatic logic [12:0] model_bus(bit act, int c, bit w, logic [7:0] a, logic [7:0] d);
        int phase;
        bit strobe;
        if (!act || c >= 6 * TP) return {5'b11110, 8'h00};
        phase  = c / TP;
        strobe = ((phase % 3) == 1);
        if (phase < 3) return {1'b0, 1'b1, ~strobe, 1'b0, 1'b1, a};
        if (w) return {1'b0, 1'b1, ~strobe, 1'b1, 1'b1, d};
        return {1'b0, ~strobe, 1'b1, 1'b1, 1'b0, 8'h00};
    endfunction

    int n_wr_a = 0, n_wr_d = 0, n_rd = 0, n_busy = 0, n_cs_fall = 0;
    logic [7:0] a_seen = 8'h00;
    logic       prev_cs_n = 1'b1;

    always @(posedge clock) begin
        logic s_rst, s_ws, s_rs, cmd_acc, status_rd, finishing, data_care;
        logic [7:0] s_port, s_out, s_adin, exp_in;
        logic [12:0] exp_bus;
        s_rst  = reset;
        s_port = port_id;
        s_ws   = write_strobe;
        s_rs   = read_strobe;
        s_out  = out_port;
        s_adin = ad_in;
        if (!s_rst) begin
            m_active = 0; m_c = 0; m_wr = 0; m_taddr = 0; m_tdata = 0;
            m_addr_stg = 0; m_wdata_stg = 0; m_rdata = 0; m_done = 0;
        end else begin
            cmd_acc   = s_ws && (s_port == 8'h12) && !m_active;
            status_rd = s_rs && (s_port == 8'h13);
            finishing = m_active && (m_c == TOTAL - 1);
            if (m_active && (m_c == 5 * TP - 1) && !m_wr) m_rdata = s_adin;
            if (finishing) m_done = 1;
            else if (status_rd || cmd_acc) m_done = 0;
            if (cmd_acc) begin
                m_active = 1; m_c = 0;
                m_taddr = m_addr_stg; m_tdata = m_wdata_stg; m_wr = s_out[0];
            end else if (m_active) begin
                if (finishing) m_active = 0;
                else m_c++;
            end
            if (s_ws && (s_port == 8'h10)) m_addr_stg = s_out;
            if (s_ws && (s_port == 8'h11)) m_wdata_stg = s_out;
        end
        #1;
        exp_bus   = model_bus(m_active, m_c, m_wr, m_taddr, m_tdata);
        data_care = exp_bus[8] || exp_bus[12];
        check("bus_ctl", {rtc_cs_n, rtc_rd_n, rtc_wr_n, rtc_ad, ad_oe}, exp_bus[12:8]);
        if (data_care) check("ad_out", ad_out, exp_bus[7:0]);
        check("busy", busy, m_active);
        exp_in = 8'h00;
        if (port_id == 8'h13) exp_in = {6'b0, m_done, m_active};
        if (port_id == 8'h14) exp_in = m_rdata;
        check("in_port", in_port, exp_in);
        if (!rtc_rd_n && !rtc_wr_n) check("rd_wr_overlap", 1, 0);
        if (!rtc_wr_n && !rtc_ad) begin n_wr_a++; a_seen = ad_out; end
        if (!rtc_wr_n && rtc_ad) n_wr_d++;
        if (!rtc_rd_n) n_rd++;
        if (busy) n_busy++;
        if (prev_cs_n && !rtc_cs_n) n_cs_fall++;
        prev_cs_n = rtc_cs_n;
    end

    // ---------------- driver tasks (called at a falling edge) ----------------
    task automatic io_write(input logic [7:0] p, input logic [7:0] d);
        port_id = p; out_port = d; write_strobe = 1'b1;
        @(negedge clock);
        write_strobe = 1'b0; port_id = 8'h00;
    endtask

    task automatic io_read(input logic [7:0] p, output logic [7:0] d);
        port_id = p; read_strobe = 1'b1;
        #1 d = in_port;
        @(negedge clock);
        read_strobe = 1'b0; port_id = 8'h00;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (m_active && n < 200) begin @(negedge clock); n++; end
        if (n >= 200) check("wait_idle_timeout", 1, 0);
    endtask

    task automatic wait_c(input int k);
        int n = 0;
        while (!(m_active && m_c == k) && n < 200) begin @(negedge clock); n++; end
        if (n >= 200) check("wait_cycle_timeout", 1, 0);
    endtask

    task automatic clr_counts();
        n_wr_a = 0; n_wr_d = 0; n_rd = 0; n_busy = 0; n_cs_fall = 0;
    endtask

    typedef struct {
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] cmd;
        logic [7:0] adin;
        logic [7:0] exp_rdata;
        int         exp_wr_d;
        int         exp_rd;
    } vec_t;

    vec_t vecs[4];

    initial begin
        logic [7:0] rd;
        logic [7:0] ports[6];
        vecs[0] = '{addr: 8'h21, wdata: 8'h45, cmd: 8'h01, adin: 8'h00, exp_rdata: 8'h00, exp_wr_d: TP, exp_rd: 0};
        vecs[1] = '{addr: 8'h22, wdata: 8'h00, cmd: 8'h00, adin: 8'h37, exp_rdata: 8'h37, exp_wr_d: 0,  exp_rd: TP};
        vecs[2] = '{addr: 8'hFF, wdata: 8'h00, cmd: 8'h01, adin: 8'hEE, exp_rdata: 8'h37, exp_wr_d: TP, exp_rd: 0};
        vecs[3] = '{addr: 8'h3C, wdata: 8'h99, cmd: 8'hFE, adin: 8'hA5, exp_rdata: 8'hA5, exp_wr_d: 0,  exp_rd: TP};
        ports = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h55};

        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("rst_cs_n", rtc_cs_n, 1'b1);
        check("rst_ad", rtc_ad, 1'b1);
        check("rst_oe", ad_oe, 1'b0);
        check("rst_ad_out", ad_out, 8'h00);
        io_read(8'h13, rd); check("rst_status", rd, 8'h00);
        io_read(8'h14, rd); check("rst_rdata", rd, 8'h00);

        for (int i = 0; i < 4; i++) begin
            clr_counts();
            ad_in = vecs[i].adin;
            io_write(8'h10, vecs[i].addr);
            io_write(8'h11, vecs[i].wdata);
            io_write(8'h12, vecs[i].cmd);
            wait_idle();
            check("vec_busy_len", n_busy, TOTAL);
            check("vec_addr_strobe", n_wr_a, TP);
            check("vec_addr_value", a_seen, vecs[i].addr);
            check("vec_data_wr", n_wr_d, vecs[i].exp_wr_d);
            check("vec_data_rd", n_rd, vecs[i].exp_rd);
            io_read(8'h13, rd); check("vec_status_done", rd, 8'h02);
            io_read(8'h13, rd); check("vec_status_clr", rd, 8'h00);
            io_read(8'h14, rd); check("vec_rdata", rd, vecs[i].exp_rdata);
        end

        // Commands during busy and gap are dropped; staging ADDR does not disturb the live address.
        clr_counts();
        io_write(8'h10, 8'h5A);
        io_write(8'h11, 8'h66);
        io_write(8'h12, 8'h01);
        wait_c(5);
        io_write(8'h12, 8'h00);
        io_write(8'h10, 8'h99);
        wait_c(6 * TP);
        io_write(8'h12, 8'h00);
        wait_idle();
        check("ign_txn_count", n_cs_fall, 1);
        check("ign_busy_len", n_busy, TOTAL);
        check("ign_addr_value", a_seen, 8'h5A);
        io_read(8'h13, rd); check("ign_status", rd, 8'h02);

        // Reset in the data strobe of a write aborts cleanly, then a new write runs to completion.
        io_write(8'h10, 8'h30);
        io_write(8'h11, 8'h77);
        io_write(8'h12, 8'h01);
        wait_c(4 * TP + 2);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        check("abort_cs_n", rtc_cs_n, 1'b1);
        check("abort_wr_n", rtc_wr_n, 1'b1);
        check("abort_oe", ad_oe, 1'b0);
        check("abort_busy", busy, 1'b0);
        io_read(8'h13, rd); check("abort_status", rd, 8'h00);
        clr_counts();
        io_write(8'h10, 8'h31);
        io_write(8'h11, 8'h78);
        io_write(8'h12, 8'h01);
        wait_idle();
        check("after_abort_busy", n_busy, TOTAL);
        check("after_abort_wr_d", n_wr_d, TP);
        io_read(8'h13, rd); check("after_abort_status", rd, 8'h02);

        // STATUS poll on the very cycle done sets: set wins.
        ad_in = 8'h5C;
        io_write(8'h10, 8'h40);
        io_write(8'h12, 8'h00);
        wait_c(TOTAL - 1);
        io_read(8'h13, rd); check("race_status_busy", rd, 8'h01);
        io_read(8'h13, rd); check("race_status_done", rd, 8'h02);
        io_read(8'h55, rd); check("unmapped_port", rd, 8'h00);
        io_read(8'h13, rd); check("race_status_clr", rd, 8'h00);
        io_read(8'h14, rd); check("race_rdata", rd, 8'h5C);

        // Random port traffic with occasional resets; the cycle model checks every output.
        for (int cyc = 0; cyc < 1500; cyc++) begin
            int r;
            write_strobe = 1'b0;
            read_strobe  = 1'b0;
            reset        = ($urandom_range(0, 399) != 0);
            r            = $urandom_range(0, 7);
            port_id      = ports[$urandom_range(0, 5)];
            out_port     = 8'($urandom);
            ad_in        = 8'($urandom);
            if (r < 2) write_strobe = 1'b1;
            else if (r == 2) read_strobe = 1'b1;
            @(negedge clock);
        end
        write_strobe = 1'b0;
        read_strobe  = 1'b0;
        reset        = 1'b1;
        port_id      = 8'h00;
        wait_idle();
        @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
